// File: rtl/mmu_feeder.sv
// rtl/mmu_feeder.sv - weight/activation sequencer driving the MMU systolic array
module mmu_feeder #(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [BIT_WIDTH*DEPTH-1:0] wt_row,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [BIT_WIDTH*DEPTH-1:0] act_vec,
  input  logic                       act_last,
  output logic                       busy,
  output logic                       done,
  output logic                       control,
  output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
  output logic [BIT_WIDTH*DEPTH-1:0] data_arr
);

  localparam int VW   = BIT_WIDTH * DEPTH;
  localparam int WT_W = $clog2(DEPTH) + 1;
  localparam int DR_W = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_WT, STREAM, DRAIN} state_t;

  state_t          state;
  state_t          next_state;
  logic [WT_W-1:0] wt_cnt;
  logic [DR_W-1:0] drain_cnt;
  logic            wt_acc;
  logic            act_acc;
  logic            last_row;
  logic            drain_end;
  logic [VW-1:0]   lane_in;

  assign wt_ready  = (state == LOAD_WT);
  assign act_ready = (state == STREAM);
  assign wt_acc    = wt_valid & wt_ready;
  assign act_acc   = act_valid & act_ready;
  assign last_row  = (wt_cnt == WT_W'(DEPTH - 1));
  assign drain_end = (drain_cnt == DR_W'(2 * DEPTH - 1));
  // Zeros enter the skew chains whenever no vector is taken (gaps, drain, idle).
  assign lane_in   = act_acc ? act_vec : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: one weight tile, then vectors until act_last, then a fixed drain.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_WT;
      LOAD_WT: if (wt_acc && last_row) next_state = STREAM;
      STREAM:  if (act_acc && act_last) next_state = DRAIN;
      DRAIN:   if (drain_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row counter for the weight tile and cycle counter for the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE:    wt_cnt <= '0;
        LOAD_WT: if (wt_acc) wt_cnt <= wt_cnt + WT_W'(1);
        STREAM:  drain_cnt <= '0;
        DRAIN:   drain_cnt <= drain_cnt + DR_W'(1);
        default: ;
      endcase
    end
  end

  // Registered status and weight-path outputs; done lands on the last drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      control <= 1'b0;
      wt_arr  <= '0;
    end else begin
      busy    <= (next_state != IDLE);
      done    <= (state == DRAIN) && (drain_cnt == DR_W'(2 * DEPTH - 2));
      control <= wt_acc;
      wt_arr  <= wt_acc ? wt_row : '0;
    end
  end

  // Diagonal skew: lane i passes through i+1 registers, the last one being the output.
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [BIT_WIDTH*(i+1)-1:0] chain;
    if (i == 0) begin : g_first
      // Lane 0 is just the output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= lane_in[0 +: BIT_WIDTH];
      end
    end else begin : g_rest
      // New value enters the low slice and moves up one slice per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[BIT_WIDTH*i-1:0], lane_in[BIT_WIDTH*i +: BIT_WIDTH]};
      end
    end
    assign data_arr[BIT_WIDTH*i +: BIT_WIDTH] = chain[BIT_WIDTH*i +: BIT_WIDTH];
  end

endmodule

// File: tb/tb_mmu_feeder.sv
// tb/tb_mmu_feeder.sv - self-checking bench for mmu_feeder
module tb_mmu_feeder;

  localparam int D  = 4;
  localparam int BW = 8;
  localparam int VW = D * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          wt_valid;
  logic          wt_ready;
  logic [VW-1:0] wt_row;
  logic          act_valid;
  logic          act_ready;
  logic [VW-1:0] act_vec;
  logic          act_last;
  logic          busy;
  logic          done;
  logic          control;
  logic [VW-1:0] wt_arr;
  logic [VW-1:0] data_arr;

  mmu_feeder #(.DEPTH(D), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_vec(act_vec), .act_last(act_last),
    .busy(busy), .done(done), .control(control), .wt_arr(wt_arr), .data_arr(data_arr)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 load, 2 stream, 3 drain; expectations scheduled by cycle index.
  int          phase = 0;
  int          wn    = 0;
  int          dleft = 0;
  int          cyc   = 0;
  bit [VW-1:0] e_wt   [0:1023];
  bit          e_ctrl [0:1023];
  bit [VW-1:0] e_data [0:1023];
  bit          e_done [0:1023];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; wn = 0; dleft = 0;
      for (int k = 0; k < 64; k++) begin
        e_wt[cyc+k] = '0; e_ctrl[cyc+k] = 0; e_data[cyc+k] = '0; e_done[cyc+k] = 0;
      end
    end else begin
      cyc++;
      case (phase)
        0: if (start) begin phase = 1; wn = 0; end
        1: if (wt_valid) begin
             e_ctrl[cyc] = 1; e_wt[cyc] = wt_row; wn++;
             if (wn == D) phase = 2;
           end
        2: if (act_valid) begin
             for (int i = 0; i < D; i++) e_data[cyc+i][BW*i +: BW] = act_vec[BW*i +: BW];
             if (act_last) begin phase = 3; dleft = 2 * D; e_done[cyc+2*D-1] = 1; end
           end
        default: begin dleft--; if (dleft == 0) phase = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("control", control, e_ctrl[cyc]);
      chk("wt_arr", wt_arr, e_wt[cyc]);
      chk("data_arr", data_arr, e_data[cyc]);
      chk("done", done, e_done[cyc]);
      chk("busy", busy, phase != 0);
      chk("wt_ready", wt_ready, phase == 1);
      chk("act_ready", act_ready, phase == 2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  logic [VW-1:0] rows1 [4];
  logic [VW-1:0] rows2 [4];
  logic [VW-1:0] skew1 [9];
  logic [VW-1:0] gap4  [6];

  initial begin
    rows1 = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    rows2 = '{32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D, 32'h4A4B4C4D};
    skew1 = '{32'h00000011, 32'h00002200, 32'h00330000, 32'h44000000,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    gap4  = '{32'h000000A1, 32'h0000A200, 32'h00A300B1, 32'hA400B200,
              32'h00B30000, 32'hB4000000};
    rst_n = 0; start = 0; wt_valid = 0; wt_row = '0;
    act_valid = 0; act_vec = '0; act_last = 0;
    repeat (2) @(negedge clk);
    chk("rst_control", control, 0);
    chk("rst_wt_arr", wt_arr, 0);
    chk("rst_data_arr", data_arr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wt_ready", wt_ready, 0);
    chk("rst_act_ready", act_ready, 0);
    rst_n = 1; chk_en = 1;

    // Weight load back-to-back, then single-vector skew and drain timing.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("t1_wt_ready", wt_ready, 1);
    for (int k = 0; k < 4; k++) begin
      wt_valid = 1; wt_row = rows1[k];
      @(negedge clk);
      chk("t1_control", control, 1);
      chk("t1_wt_arr", wt_arr, rows1[k]);
    end
    wt_valid = 0;
    chk("t1_wt_ready_off", wt_ready, 0);
    chk("t1_act_ready", act_ready, 1);
    act_valid = 1; act_vec = 32'h44332211; act_last = 1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      act_valid = 0; act_last = 0; act_vec = '0;
      if (k == 0) chk("t1_control_end", control, 0);
      chk("t3_skew", data_arr, skew1[k]);
      chk("t3_done", done, k == 7);
      if (k == 7) chk("t3_busy_last", busy, 1);
      if (k == 8) chk("t3_idle", busy, 0);
    end

    // Weight bubble, with act_* driven junk that must be ignored in LOAD_WT.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    act_valid = 1; act_vec = 32'hFFFFFFFF; act_last = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) wt_valid = 0;
      else begin wt_valid = 1; wt_row = rows2[(k < 2) ? k : k - 1]; end
      @(negedge clk);
      if (k == 2) begin
        chk("t2_bubble_ctrl", control, 0);
        chk("t2_bubble_wt", wt_arr, 0);
        chk("t2_bubble_data", data_arr, 0);
      end else begin
        chk("t2_wt_arr", wt_arr, rows2[(k < 2) ? k : k - 1]);
      end
    end
    wt_valid = 0; act_valid = 0; act_last = 0;

    // Stream gaps: A, gap (junk data, wt_valid junk), B last.
    act_valid = 1; act_vec = 32'hA4A3A2A1;
    @(negedge clk);
    chk("t4_gap", data_arr, gap4[0]);
    act_valid = 0; act_vec = 32'hDEADBEEF; wt_valid = 1; wt_row = 32'h55555555;
    @(negedge clk);
    chk("t4_gap", data_arr, gap4[1]);
    act_valid = 1; act_vec = 32'hB4B3B2B1; act_last = 1; wt_valid = 0;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      act_valid = 0; act_last = 0; act_vec = '0;
      chk("t4_gap", data_arr, gap4[k]);
    end
    repeat (5) @(negedge clk);
    chk("t4_idle", busy, 0);

    // Start held high for a whole job; restart only from IDLE.
    start = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wt_valid = 1; wt_row = rows1[3-k];
      @(negedge clk);
      chk("t5_busy", busy, 1);
    end
    wt_valid = 0;
    act_valid = 1; act_vec = 32'h0F0E0D0C; act_last = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      act_valid = 0; act_last = 0;
      chk("t5_busy_run", busy, 1);
      chk("t5_wt_ready", wt_ready, 0);
    end
    @(negedge clk);
    chk("t5_idle_gap", busy, 0);
    @(negedge clk);
    start = 0;
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_ready", wt_ready, 1);

    // Reset in the middle of a stream.
    for (int k = 0; k < 4; k++) begin
      wt_valid = 1; wt_row = rows2[k];
      @(negedge clk);
    end
    wt_valid = 0;
    for (int k = 0; k < 3; k++) begin
      act_valid = 1; act_vec = 32'h81828384 + k;
      @(negedge clk);
    end
    #2 rst_n = 0;
    #1;
    chk("t6_control", control, 0);
    chk("t6_wt_arr", wt_arr, 0);
    chk("t6_data_arr", data_arr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_act_ready", act_ready, 0);
    act_valid = 0; act_vec = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_wt_ready", wt_ready, 0);
    chk("t6_post_act_ready", act_ready, 0);
    @(negedge clk);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
